// File: rtl/ssf_pkg.sv
// Shared types and constants for the SSF multi-channel front end.
// Optional build macro used by ssf_array_sched: SSF_RR_ARB_EN (round-robin out_en grant).
package ssf_pkg;

  // A channel field is active only when it carries this code.
  localparam logic [1:0] ACT_CODE = 2'd1;

  // Default number of clocks between consecutive channel reset releases.
  localparam int DEF_STAGGER = 1046;

  // Width of the per-channel req_in / out_en fields.
  localparam int CTRL_W = 2;

  // Width of one command slot on io_in as decoded by the ssf core model.
  localparam int CMD_W = 8;

  typedef enum logic [0:0] {
    SEQ = 1'b0,
    RUN = 1'b1
  } seq_state_t;

  typedef logic [CTRL_W-1:0] ssf_ctrl_t;

  // True when a channel control field carries the active code.
  function automatic logic is_act(input ssf_ctrl_t f);
    return (f == ACT_CODE);
  endfunction

endpackage

// File: rtl/ssf.sv
// SSF channel core (behavioural model so the slice elaborates on its own).
// io_in is viewed as DATA_W/8 command bytes; channel CH uses byte CH mod (DATA_W/8):
//   [1:0] out_en, [3:2] req_in, [7:4] signed sample (sign-extended onto io_out).
// All outputs are registered and held at zero while rst is high. Needs DATA_W >= 8.
module ssf
  import ssf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CH     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] io_in,
  output logic signed [DATA_W-1:0] io_out,
  output logic [CTRL_W-1:0]        req_in,
  output logic [CTRL_W-1:0]        out_en
);

  localparam int SLOTS = DATA_W / CMD_W;
  localparam int SLOT  = CH % SLOTS;

  logic [CMD_W-1:0] cmd_s;
  logic             unused_bits_s;

  assign cmd_s         = io_in[SLOT*CMD_W +: CMD_W];
  assign unused_bits_s = ^io_in;

  // Latch this channel's command byte; zero everything while in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      io_out <= {DATA_W{1'b0}};
      req_in <= 2'd0;
      out_en <= 2'd0;
    end else begin
      io_out <= {{(DATA_W-4){cmd_s[7]}}, cmd_s[7:4]};
      req_in <= cmd_s[3:2];
      out_en <= cmd_s[1:0];
    end
  end

endmodule

// File: rtl/ssf_rst_seq.sv
// Staggered reset release for NUM_CH channels.
// Channel k leaves reset on edge 1+k*STAGGER after rst falls; all_running rises on the
// same edge that releases the last channel, and the sequencer then parks in RUN until rst.
module ssf_rst_seq
  import ssf_pkg::*;
#(
  parameter int NUM_CH  = 31,
  parameter int STAGGER = DEF_STAGGER
) (
  input  logic              clk,
  input  logic              rst,
  output logic [NUM_CH-1:0] ch_rst,
  output logic              all_running
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;

  seq_state_t        state_r;
  seq_state_t        next_state_s;
  logic [IDX_W-1:0]  idx_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [NUM_CH-1:0] release_s;
  logic              set_run_s;
  logic              last_rel_s;

  // The last channel is released when the index reaches it with the counter at zero.
  assign last_rel_s = (idx_r == IDX_W'(NUM_CH-1)) && (cnt_r == {CNT_W{1'b0}});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= SEQ;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state: SEQ until the last channel is released, RUN is terminal.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      SEQ: begin
        if (last_rel_s) begin
          next_state_s = RUN;
        end else begin
          next_state_s = SEQ;
        end
      end
      RUN:     next_state_s = RUN;
      default: next_state_s = SEQ;
    endcase
  end

  // Output decode: which channel to release this edge and whether to flag all running.
  always_comb begin
    release_s = {NUM_CH{1'b0}};
    set_run_s = 1'b0;
    case (state_r)
      SEQ: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          release_s = {{(NUM_CH-1){1'b0}}, 1'b1} << idx_r;
        end else begin
          release_s = {NUM_CH{1'b0}};
        end
        set_run_s = last_rel_s;
      end
      RUN: begin
        release_s = {NUM_CH{1'b0}};
        set_run_s = 1'b0;
      end
      default: begin
        release_s = {NUM_CH{1'b0}};
        set_run_s = 1'b0;
      end
    endcase
  end

  // Stagger counter, channel index and the registered reset/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_rst      <= {NUM_CH{1'b1}};
      all_running <= 1'b0;
      idx_r       <= {IDX_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
    end else begin
      ch_rst      <= ch_rst & ~release_s;
      all_running <= all_running | set_run_s;
      if (state_r == SEQ) begin
        if (cnt_r == CNT_W'(STAGGER-1)) begin
          cnt_r <= {CNT_W{1'b0}};
          idx_r <= (idx_r == IDX_W'(NUM_CH-1)) ? idx_r : idx_r + IDX_W'(1);
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
          idx_r <= idx_r;
        end
      end else begin
        cnt_r <= cnt_r;
        idx_r <= idx_r;
      end
    end
  end

endmodule

// File: rtl/ssf_array_sched.sv
// Multi-channel SSF front end: NUM_CH ssf cores on a shared io_in, staggered reset release,
// and one registered output bus carrying the granted channel's sample.
// Build option: define SSF_RR_ARB_EN for round-robin out_en grant (pointer resets so ch0 wins
// first); otherwise fixed priority with the lowest active index winning.
module ssf_array_sched
  import ssf_pkg::*;
#(
  parameter int NUM_CH  = 31,
  parameter int DATA_W  = 32,
  parameter int STAGGER = DEF_STAGGER,
  parameter int IDX_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] io_in,
  output logic signed [DATA_W-1:0] my_io_out,
  output logic [1:0]               my_req_in,
  output logic [1:0]               my_out_en,
  output logic [IDX_W-1:0]         my_grant,
  output logic                     all_running,
  output logic                     collision
);

  logic [NUM_CH-1:0]        ch_rst_s;
  logic signed [DATA_W-1:0] core_out_s [NUM_CH];
  ssf_ctrl_t                core_req_s [NUM_CH];
  ssf_ctrl_t                core_oe_s  [NUM_CH];

  logic [NUM_CH-1:0]        act_s;
  logic                     req_any_s;
  logic                     collide_s;
  logic                     seen_s;
  logic                     grant_vld_s;
  logic [IDX_W-1:0]         grant_idx_s;

  ssf_rst_seq #(
    .NUM_CH  (NUM_CH),
    .STAGGER (STAGGER)
  ) u_seq (
    .clk         (clk),
    .rst         (rst),
    .ch_rst      (ch_rst_s),
    .all_running (all_running)
  );

  for (genvar k = 0; k < NUM_CH; k++) begin : g_core
    ssf #(
      .DATA_W (DATA_W),
      .CH     (k)
    ) u_core (
      .clk    (clk),
      .rst    (ch_rst_s[k]),
      .io_in  (io_in),
      .io_out (core_out_s[k]),
      .req_in (core_req_s[k]),
      .out_en (core_oe_s[k])
    );
  end

  // Active-channel vector, any-request flag and two-or-more-active detection.
  always_comb begin
    act_s     = {NUM_CH{1'b0}};
    req_any_s = 1'b0;
    collide_s = 1'b0;
    seen_s    = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      act_s[k]  = is_act(core_oe_s[k]);
      req_any_s = req_any_s | is_act(core_req_s[k]);
      collide_s = collide_s | (act_s[k] & seen_s);
      seen_s    = seen_s | act_s[k];
    end
  end

`ifdef SSF_RR_ARB_EN
  logic [IDX_W-1:0] ptr_r;

  // Round-robin search from ptr_r+1; scanned high offset to low so the nearest match wins.
  always_comb begin
    int cand_s;
    cand_s      = 0;
    grant_vld_s = 1'b0;
    grant_idx_s = {IDX_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand_s = (int'(ptr_r) + 1 + i) % NUM_CH;
      if (act_s[cand_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = IDX_W'(cand_s);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Last-grant pointer; moves only on cycles that produce a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= IDX_W'(NUM_CH-1);
    end else if (grant_vld_s) begin
      ptr_r <= grant_idx_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  // Fixed priority: scanned high to low so the lowest active index wins.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = {IDX_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (act_s[i]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = IDX_W'(i);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end
`endif

  // Registered output bus; losing channels' samples are simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      my_io_out <= {DATA_W{1'b0}};
      my_req_in <= 2'd0;
      my_out_en <= 2'd0;
      my_grant  <= {IDX_W{1'b0}};
      collision <= 1'b0;
    end else begin
      my_io_out <= grant_vld_s ? core_out_s[grant_idx_s] : {DATA_W{1'b0}};
      my_req_in <= req_any_s ? ACT_CODE : 2'd0;
      my_out_en <= grant_vld_s ? ACT_CODE : 2'd0;
      my_grant  <= grant_vld_s ? grant_idx_s : {IDX_W{1'b0}};
      collision <= collide_s;
    end
  end

endmodule

// File: tb/tb_ssf_array_sched.sv
// Directed bench for ssf_array_sched: small instance (4 ch, stagger 8) for sequencing and
// arbitration, plus a default-parameter instance for the full-length release timing.
module tb_ssf_array_sched;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int ST = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] io_in;
  logic [DW-1:0] my_io_out;
  logic [1:0]    my_req_in;
  logic [1:0]    my_out_en;
  logic [1:0]    my_grant;
  logic          all_running;
  logic          collision;

  logic          rst_def;
  logic [DW-1:0] d_io_out;
  logic [1:0]    d_req_in;
  logic [1:0]    d_out_en;
  logic [4:0]    d_grant;
  logic          d_running;
  logic          d_collision;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ssf_array_sched #(.NUM_CH(NC), .DATA_W(DW), .STAGGER(ST)) dut (
    .clk(clk), .rst(rst), .io_in(io_in), .my_io_out(my_io_out), .my_req_in(my_req_in),
    .my_out_en(my_out_en), .my_grant(my_grant), .all_running(all_running),
    .collision(collision)
  );

  ssf_array_sched dut_def (
    .clk(clk), .rst(rst_def), .io_in(32'h0000_0000), .my_io_out(d_io_out),
    .my_req_in(d_req_in), .my_out_en(d_out_en), .my_grant(d_grant),
    .all_running(d_running), .collision(d_collision)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected channel-reset vector n edges after rst fell.
  function automatic logic [NC-1:0] exp_rst(input int n);
    logic [NC-1:0] v;
    for (int k = 0; k < NC; k++) v[k] = (n >= 1 + k*ST) ? 1'b0 : 1'b1;
    return v;
  endfunction

  // Walk release edges from_n..to_n checking channel resets and all_running.
  task automatic seq_walk(input string tag, input int from_n, input int to_n);
    for (int n = from_n; n <= to_n; n++) begin
      tick();
      check_eq({tag, "_ch_rst"}, 64'(dut.ch_rst_s), 64'(exp_rst(n)));
      check_eq({tag, "_running"}, 64'(all_running), 64'(n >= 1 + (NC-1)*ST));
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_oe"}, 64'(my_out_en), 64'd0);
    check_eq({tag, "_io"}, 64'(my_io_out), 64'd0);
    check_eq({tag, "_grant"}, 64'(my_grant), 64'd0);
    check_eq({tag, "_coll"}, 64'(collision), 64'd0);
  endtask

  initial begin
    int n;
    logic [1:0]  g_exp [4];
    logic [31:0] d_exp [4];

    rst = 1'b1; rst_def = 1'b1; io_in = 32'h0000_0000;
    repeat (3) tick();
    check_eq("rst_ch_rst", 64'(dut.ch_rst_s), 64'hF);
    check_eq("rst_running", 64'(all_running), 64'd0);
    check_eq("rst_req", 64'(my_req_in), 64'd0);
    check_idle("rst");

    // Test 1: releases on edges 1,9,17,25.
    rst = 1'b0;
    seq_walk("t1", 1, 26);

    // Test 2: rst pulse at edge 12 restarts the sequence.
    rst = 1'b1; tick(); rst = 1'b0;
    seq_walk("t2a", 1, 11);
    rst = 1'b1; tick();
    check_eq("t2_rst_all", 64'(dut.ch_rst_s), 64'hF);
    check_eq("t2_rst_run", 64'(all_running), 64'd0);
    rst = 1'b0;
    seq_walk("t2b", 1, 25);

    // Test 4: ch1 (sample 2) and ch3 (sample -1) hold out_en=1 for 4 cycles.
`ifdef SSF_RR_ARB_EN
    g_exp = '{2'd1, 2'd3, 2'd1, 2'd3};
    d_exp = '{32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
`else
    g_exp = '{2'd1, 2'd1, 2'd1, 2'd1};
    d_exp = '{32'h0000_0002, 32'h0000_0002, 32'h0000_0002, 32'h0000_0002};
`endif
    io_in = 32'hF100_2100;
    tick();
    for (int j = 0; j < 4; j++) begin
      tick();
      check_eq("t4_grant", 64'(my_grant), 64'(g_exp[j]));
      check_eq("t4_io", 64'(my_io_out), 64'(d_exp[j]));
      check_eq("t4_oe", 64'(my_out_en), 64'd1);
      check_eq("t4_coll", 64'(collision), 64'd1);
      if (j == 2) io_in = 32'h0000_0000;
    end
    tick();
    check_idle("t4_end");

    // Test 3: ch1 -5 and ch3 7 both active; ch1 wins in either arbitration mode here.
    io_in = 32'h7100_B100;
    tick(); tick();
    check_eq("t3_grant", 64'(my_grant), 64'd1);
    check_eq("t3_io", 64'(my_io_out), 64'hFFFF_FFFB);
    check_eq("t3_oe", 64'(my_out_en), 64'd1);
    check_eq("t3_coll", 64'(collision), 64'd1);
    io_in = 32'h0000_0000;
    tick(); tick();
    check_idle("t3_end");

    // Single active channel ch2 with sample 3: no collision.
    io_in = 32'h0031_0000;
    tick(); tick();
    check_eq("one_grant", 64'(my_grant), 64'd2);
    check_eq("one_io", 64'(my_io_out), 64'd3);
    check_eq("one_oe", 64'(my_out_en), 64'd1);
    check_eq("one_coll", 64'(collision), 64'd0);

    // Test 5: ch2 out_en=3, req_in=2 are not active codes.
    io_in = 32'h000B_0000;
    tick(); tick();
    check_eq("t5_req", 64'(my_req_in), 64'd0);
    check_idle("t5");

    // ch0 req_in=1 only: request flag without a grant.
    io_in = 32'h0000_0004;
    tick(); tick();
    check_eq("req_req", 64'(my_req_in), 64'd1);
    check_eq("req_oe", 64'(my_out_en), 64'd0);
    io_in = 32'h0000_0000;
    tick(); tick();
    check_eq("req_clr", 64'(my_req_in), 64'd0);

    // Test 6: default parameters, all_running 31381 edges after rst falls.
    check_eq("t6_rst_run", 64'(d_running), 64'd0);
    rst_def = 1'b0;
    n = 0;
    while (n <= 40000) begin
      tick();
      n++;
      if (d_running) break;
    end
    check_eq("t6_edges", 64'(n), 64'd31381);
    check_eq("t6_oe", 64'(d_out_en), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
